// File: rtl/ether_pkg.sv
// Shared types and MDIO constants for the ether block management path.
package ether_pkg;

  localparam int PHY_BITS      = 5;
  localparam int REG_BITS      = 5;
  localparam int MD_DATA_BITS  = 16;
  localparam int BMSR_REG      = 1;
  localparam int BMSR_LINK_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMPLETE
  } sched_state_t;

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll interval counter; emits a 1-cycle tick on each wrap.
module mdio_poll_timer #(
  parameter int POLL_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_BITS = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                wrap;

  assign wrap   = (cnt_q == CNT_BITS'(POLL_CYCLES - 1));
  assign tick_o = en_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || wrap) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mdio_sched.sv
// Arbitrates the shared MDIO engine between host commands and the link poller,
// and maintains the per-channel link_up vector from periodic BMSR reads.
module mdio_sched
  import ether_pkg::*;
#(
  parameter int NETHER          = 1,
  parameter int NETHER_BITS     = $clog2(NETHER + 1),
  parameter int POLL_CYCLES     = 12000000,
  parameter int POLL_REG        = BMSR_REG,
  parameter int LINK_BIT        = BMSR_LINK_BIT,
  parameter int MAX_HOST_STREAK = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_req,
  input  logic                       host_rdwr,
  input  logic [NETHER_BITS-1:0]     host_channel,
  input  logic [PHY_BITS-1:0]        host_phy,
  input  logic [REG_BITS-1:0]        host_reg,
  input  logic [MD_DATA_BITS-1:0]    host_wdata,
  output logic                       host_ack,
  output logic                       host_done,
  output logic [MD_DATA_BITS-1:0]    host_rdata,
  input  logic                       poll_enable,
  input  logic [PHY_BITS*NETHER-1:0] poll_phy,
  output logic                       eng_start,
  output logic                       eng_rdwr,
  output logic [NETHER_BITS-1:0]     eng_channel,
  output logic [PHY_BITS-1:0]        eng_phy,
  output logic [REG_BITS-1:0]        eng_reg,
  output logic [MD_DATA_BITS-1:0]    eng_wdata,
  input  logic                       eng_done,
  input  logic [MD_DATA_BITS-1:0]    eng_rdata,
  output logic [NETHER-1:0]          link_up,
  output logic                       link_event,
  output logic [NETHER-1:0]          link_change_mask
);

  localparam int STREAK_BITS = $clog2(MAX_HOST_STREAK + 1);
  localparam int NCH         = 2 ** NETHER_BITS;

  sched_state_t            state_q, state_d;
  logic [STREAK_BITS-1:0]  streak_q, streak_d;
  logic                    round_q, round_d;
  logic [NETHER_BITS-1:0]  poll_ch_q, poll_ch_d;
  logic                    is_poll_q, is_poll_d;
  logic                    eng_rdwr_q, eng_rdwr_d;
  logic [NETHER_BITS-1:0]  eng_channel_q, eng_channel_d;
  logic [PHY_BITS-1:0]     eng_phy_q, eng_phy_d;
  logic [REG_BITS-1:0]     eng_reg_q, eng_reg_d;
  logic [MD_DATA_BITS-1:0] eng_wdata_q, eng_wdata_d;
  logic [MD_DATA_BITS-1:0] host_rdata_q, host_rdata_d;
  logic [NETHER-1:0]       link_up_q, link_up_d;
  logic                    link_event_q, link_event_d;
  logic [NETHER-1:0]       mask_q, mask_d;

  logic                    tick, poll_pend, host_win, poll_win, new_link;
  logic [NETHER-1:0]       ch_mask;
  logic [PHY_BITS-1:0]     phy_tab [NCH];

  // Pad the per-channel PHY table to a power of two so poll_ch_q indexes it directly.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_phy
      if (gi < NETHER) begin : g_real
        assign phy_tab[gi] = poll_phy[gi*PHY_BITS +: PHY_BITS];
      end else begin : g_pad
        assign phy_tab[gi] = '0;
      end
    end
  endgenerate

  mdio_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (poll_enable),
    .tick_o (tick)
  );

  assign poll_pend = round_q & poll_enable;
  assign host_win  = host_req & ~(poll_pend & (streak_q == STREAK_BITS'(MAX_HOST_STREAK)));
  assign poll_win  = poll_pend & ~host_win;
  assign ch_mask   = NETHER'(1) << poll_ch_q;
  assign new_link  = eng_rdata[LINK_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (host_win || poll_win) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT;
      ST_WAIT:     if (eng_done) state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host_ack  = (state_q == ST_IDLE) && host_win;
    eng_start = (state_q == ST_ISSUE);
    host_done = (state_q == ST_COMPLETE) && !is_poll_q;
  end

  always_comb begin
    streak_d      = streak_q;
    round_d       = round_q;
    poll_ch_d     = poll_ch_q;
    is_poll_d     = is_poll_q;
    eng_rdwr_d    = eng_rdwr_q;
    eng_channel_d = eng_channel_q;
    eng_phy_d     = eng_phy_q;
    eng_reg_d     = eng_reg_q;
    eng_wdata_d   = eng_wdata_q;
    host_rdata_d  = host_rdata_q;
    link_up_d     = link_up_q;
    link_event_d  = 1'b0;
    mask_d        = '0;

    // A tick while a round is still running is dropped, never queued.
    if (tick && !round_q) begin
      round_d   = 1'b1;
      poll_ch_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (round_q && !poll_enable) round_d = 1'b0;
        if (host_win) begin
          is_poll_d     = 1'b0;
          eng_rdwr_d    = host_rdwr;
          eng_channel_d = host_channel;
          eng_phy_d     = host_phy;
          eng_reg_d     = host_reg;
          eng_wdata_d   = host_wdata;
          if (streak_q != STREAK_BITS'(MAX_HOST_STREAK)) streak_d = streak_q + 1'b1;
        end else if (poll_win) begin
          is_poll_d     = 1'b1;
          eng_rdwr_d    = 1'b1;
          eng_channel_d = poll_ch_q;
          eng_phy_d     = phy_tab[poll_ch_q];
          eng_reg_d     = REG_BITS'(POLL_REG);
          eng_wdata_d   = '0;
          streak_d      = '0;
        end
      end
      ST_WAIT: begin
        if (eng_done) begin
          if (is_poll_q) begin
            if (new_link != |(link_up_q & ch_mask)) begin
              link_up_d    = new_link ? (link_up_q | ch_mask) : (link_up_q & ~ch_mask);
              link_event_d = 1'b1;
              mask_d       = ch_mask;
            end
          end else begin
            host_rdata_d = eng_rdwr_q ? eng_rdata : '0;
          end
        end
      end
      ST_COMPLETE: begin
        if (is_poll_q) begin
          if (poll_ch_q == NETHER_BITS'(NETHER - 1) || !poll_enable) round_d = 1'b0;
          else poll_ch_d = poll_ch_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q      <= '0;
      round_q       <= 1'b0;
      poll_ch_q     <= '0;
      is_poll_q     <= 1'b0;
      eng_rdwr_q    <= 1'b0;
      eng_channel_q <= '0;
      eng_phy_q     <= '0;
      eng_reg_q     <= '0;
      eng_wdata_q   <= '0;
      host_rdata_q  <= '0;
      link_up_q     <= '0;
      link_event_q  <= 1'b0;
      mask_q        <= '0;
    end else begin
      streak_q      <= streak_d;
      round_q       <= round_d;
      poll_ch_q     <= poll_ch_d;
      is_poll_q     <= is_poll_d;
      eng_rdwr_q    <= eng_rdwr_d;
      eng_channel_q <= eng_channel_d;
      eng_phy_q     <= eng_phy_d;
      eng_reg_q     <= eng_reg_d;
      eng_wdata_q   <= eng_wdata_d;
      host_rdata_q  <= host_rdata_d;
      link_up_q     <= link_up_d;
      link_event_q  <= link_event_d;
      mask_q        <= mask_d;
    end
  end

  assign eng_rdwr         = eng_rdwr_q;
  assign eng_channel      = eng_channel_q;
  assign eng_phy          = eng_phy_q;
  assign eng_reg          = eng_reg_q;
  assign eng_wdata        = eng_wdata_q;
  assign host_rdata       = host_rdata_q;
  assign link_up          = link_up_q;
  assign link_event       = link_event_q;
  assign link_change_mask = mask_q;

endmodule

// File: tb/tb_mdio_sched.sv
// Directed bench for mdio_sched: behavioural MDIO engine plus a host_rdata scoreboard.
module tb_mdio_sched;

  localparam int NETHER = 2;
  localparam int NB     = 2;
  localparam int POLL   = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_rdwr;
  logic [NB-1:0] host_channel;
  logic [4:0]  host_phy, host_reg;
  logic [15:0] host_wdata;
  logic        host_ack, host_done;
  logic [15:0] host_rdata;
  logic        poll_enable;
  logic [9:0]  poll_phy;
  logic        eng_start, eng_rdwr;
  logic [NB-1:0] eng_channel;
  logic [4:0]  eng_phy, eng_reg;
  logic [15:0] eng_wdata;
  logic        eng_done;
  logic [15:0] eng_rdata;
  logic [NETHER-1:0] link_up, link_change_mask;
  logic        link_event;

  mdio_sched #(
    .NETHER(NETHER), .NETHER_BITS(NB), .POLL_CYCLES(POLL),
    .POLL_REG(1), .LINK_BIT(2), .MAX_HOST_STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_rdwr(host_rdwr), .host_channel(host_channel),
    .host_phy(host_phy), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_done(host_done), .host_rdata(host_rdata),
    .poll_enable(poll_enable), .poll_phy(poll_phy),
    .eng_start(eng_start), .eng_rdwr(eng_rdwr), .eng_channel(eng_channel),
    .eng_phy(eng_phy), .eng_reg(eng_reg), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdata(eng_rdata),
    .link_up(link_up), .link_event(link_event), .link_change_mask(link_change_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rdwr;
    logic [1:0] ch;
    logic [4:0] phy;
    logic [4:0] rg;
  } start_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cyc = -10;
  int          eng_delay = 3;
  int          stab_err = 0;
  int          n_evt = 0;
  logic [1:0]  last_mask = '0;
  logic [15:0] default_rdata = 16'h0004;
  logic [15:0] host_exp = '0;
  logic [15:0] sb[$];
  logic [15:0] resp[$];
  start_t      slog[$];
  bit          eng_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard push on grant, pop/compare on completion, engine start log.
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_ack) sb.push_back(host_exp);
      if (host_done) begin
        check("host_done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("host_rdata", 32'(host_rdata), 32'(sb.pop_front()));
        check("host_done_latency", 32'(cyc), 32'(done_cyc + 1));
      end
      if (eng_start) slog.push_back('{cyc, eng_rdwr, eng_channel, eng_phy, eng_reg});
      if (link_event) begin
        n_evt++;
        last_mask = link_change_mask;
      end
    end
  end

  // Behavioural MDIO engine: fixed latency, checks field stability while busy.
  initial begin
    logic [32:0] snap;
    bit aborted;
    eng_done = 1'b0;
    eng_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start) begin
        eng_busy = 1;
        aborted = 0;
        snap = {eng_rdwr, eng_channel, eng_phy, eng_reg, eng_wdata};
        for (int k = 0; k < eng_delay; k++) begin
          @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          if ({eng_rdwr, eng_channel, eng_phy, eng_reg, eng_wdata} !== snap) stab_err++;
        end
        if (!aborted) begin
          @(posedge clk); #1;
          eng_done = 1'b1;
          eng_rdata = (resp.size() != 0) ? resp.pop_front() : default_rdata;
          done_cyc = cyc;
          @(posedge clk); #1;
          eng_done = 1'b0;
          eng_rdata = '0;
        end
        eng_busy = 0;
      end
    end
  end

  function automatic bit is_poll(input start_t s);
    return (s.rg == 5'd1) && s.rdwr;
  endfunction

  task automatic host_op(input logic rdwr, input logic [1:0] ch, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] exp);
    bit ok;
    @(posedge clk); #1;
    host_rdwr = rdwr; host_channel = ch; host_phy = phy; host_reg = rg; host_wdata = wd;
    host_exp = exp;
    host_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (host_ack) begin ok = 1; break; end
    end
    check("host_ack_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    check("start_after_ack", 32'(eng_start), 32'd1);
    check("start_fields", {eng_rdwr, eng_channel, eng_phy, eng_reg, eng_wdata},
          {rdwr, ch, phy, rg, (rdwr ? eng_wdata : wd)});
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (host_done) begin ok = 1; break; end
    end
    check("host_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1; break; end
    end
  endtask

  task automatic wait_engine_idle();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!eng_busy) break;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int  e, base, npoll, p0, hosts, idx, cnt_early;
    bit  ok, fin;
    rst_n = 1'b0;
    host_req = 0; host_rdwr = 0; host_channel = '0; host_phy = '0; host_reg = '0;
    host_wdata = '0; poll_enable = 0; poll_phy = {5'd2, 5'd1};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {host_ack, host_done, eng_start, link_event}, 32'd0);
    check("reset_data", {host_rdata, eng_rdwr, eng_channel, eng_phy, eng_reg, eng_wdata}, 32'd0);
    check("reset_link", {link_up, link_change_mask}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Host read and write through the scoreboard.
    resp.push_back(16'h1234);
    host_op(1'b1, 2'd0, 5'd3, 5'd2, 16'h0000, 16'h1234);
    resp.push_back(16'hFFFF);
    host_op(1'b0, 2'd1, 5'd5, 5'd0, 16'h8000, 16'h0000);
    repeat (3) @(negedge clk);

    // One poll round: 200 counts, one cycle to grant, one to issue.
    n_evt = 0;
    resp.push_back(16'h0004);
    resp.push_back(16'h0000);
    @(posedge clk); #1 poll_enable = 1'b1; e = cyc;
    wait_start(300, ok);
    check("poll0_seen", 32'(ok), 32'd1);
    check("poll0_time", 32'(cyc), 32'(e + 201));
    check("poll0_fields", {eng_rdwr, eng_channel, eng_phy, eng_reg}, {1'b1, 2'd0, 5'd1, 5'd1});
    wait_start(50, ok);
    check("poll1_seen", 32'(ok), 32'd1);
    check("poll1_fields", {eng_rdwr, eng_channel, eng_phy, eng_reg}, {1'b1, 2'd1, 5'd2, 5'd1});
    repeat (10) @(negedge clk);
    poll_enable = 1'b0;
    check("poll_link_up", 32'(link_up), 32'b01);
    check("poll_event_count", 32'(n_evt), 32'd1);
    check("poll_event_mask", 32'(last_mask), 32'b01);

    // Host held continuously while a round is pending.
    n_evt = 0;
    eng_delay = 2;
    base = slog.size();
    @(posedge clk); #1;
    poll_enable = 1'b1;
    host_rdwr = 1'b0; host_channel = 2'd0; host_phy = 5'd4; host_reg = 5'd7;
    host_wdata = 16'h55AA; host_exp = 16'h0000; host_req = 1'b1;
    fin = 0;
    for (int k = 0; k < 800 && !fin; k++) begin
      @(negedge clk);
      npoll = 0;
      for (int i = base; i < slog.size(); i++) begin
        if (is_poll(slog[i])) npoll++;
        else if (npoll == 2) fin = 1;
      end
    end
    check("streak_phase_done", 32'(fin), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
    poll_enable = 1'b0;
    repeat (20) @(negedge clk);
    p0 = -1;
    for (int i = base; i < slog.size(); i++) if (p0 < 0 && is_poll(slog[i])) p0 = i;
    hosts = 0;
    idx = (p0 < 0) ? slog.size() : p0 + 1;
    while (idx < slog.size() && !is_poll(slog[idx])) begin hosts++; idx++; end
    check("streak_host_grants", 32'(hosts), 32'd4);
    check("streak_poll_ch", 32'((idx < slog.size()) ? slog[idx].ch : 2'd3), 32'd1);
    check("streak_host_resumes",
          32'((idx + 1 < slog.size()) ? !is_poll(slog[idx + 1]) : 1'b0), 32'd1);
    check("streak_link_up", 32'(link_up), 32'b11);
    check("streak_event_mask", {n_evt[15:0], 14'd0, last_mask}, {16'd1, 14'd0, 2'b10});

    // Slow engine: overlapping ticks are dropped, rounds never overlap.
    eng_delay = 250;
    base = slog.size();
    @(posedge clk); #1 poll_enable = 1'b1; e = cyc;
    repeat (1000) @(negedge clk);
    cnt_early = 0;
    for (int i = base; i < slog.size(); i++) if (slog[i].cyc <= e + 790) cnt_early++;
    check("drop_first_round_reads", 32'(cnt_early), 32'd2);
    check("drop_total_reads", 32'(slog.size() - base), 32'd3);
    if (slog.size() - base >= 3)
      check("drop_order", {slog[base].ch, slog[base+1].ch, slog[base+2].ch}, {2'd0, 2'd1, 2'd0});
    @(posedge clk); #1 poll_enable = 1'b0;
    wait_engine_idle();
    check("abandon_rest_of_round", 32'(slog.size() - base), 32'd3);

    // Async reset while the engine is busy with a host read.
    eng_delay = 50;
    @(posedge clk); #1;
    host_rdwr = 1'b1; host_channel = 2'd1; host_phy = 5'd6; host_reg = 5'd3;
    host_exp = 16'hDEAD; host_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (host_ack) begin ok = 1; break; end
    end
    check("rst_test_ack", 32'(ok), 32'd1);
    @(posedge clk); #1 host_req = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {host_ack, host_done, eng_start, link_event}, 32'd0);
    check("async_reset_fields", {eng_rdwr, eng_channel, eng_phy, eng_reg, eng_wdata}, 32'd0);
    check("async_reset_link", {link_up, link_change_mask}, 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 poll_enable = 1'b1; e = cyc;
    wait_start(300, ok);
    check("post_reset_poll_seen", 32'(ok), 32'd1);
    check("post_reset_poll_time", 32'(cyc), 32'(e + 201));
    check("post_reset_poll_ch", 32'(eng_channel), 32'd0);
    poll_enable = 1'b0;
    wait_engine_idle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("eng_fields_stable", 32'(stab_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
